ram_bist: RTL and testbench

- Built-in self-test initiator that drives the single-port register-file RAM interface: we, adr, din out; dout back, asynchronous read.
- The RAM it tests has address 0 hard-wired to read zero.
- On command, runs a March C- sequence over addresses 1..2^N-1, checks that address 0 reads zero, and reports pass/fail plus the first failing address.
- Sits between the control logic and the RAM instance. Its outputs connect directly to the RAM ports.

---
 rtl/ram_bist.sv | 160 ++++++++++++++++
 tb/tb_ram_bist.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March C- built-in self-test initiator for a single-port register-file RAM
// whose address 0 is hard-wired to read zero. Reports pass/fail and the first
// failing address; aborts on the first mismatch.
module ram_bist #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] fail_adr,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  localparam logic [N-1:0] ADR_FIRST = N'(1);
  localparam logic [N-1:0] ADR_LAST  = '1;
  localparam logic [M-1:0] P0        = '0;
  localparam logic [M-1:0] P1        = '1;

  typedef enum logic [3:0] {
    IDLE, ZCHK, M0, M1R, M1W, M2R, M2W, M3R, M3W, M4R, M4W, M5
  } state_t;

  state_t         state;
  logic [N-1:0]   adr;
  logic           rd_c;
  logic [M-1:0]   exp_c;
  logic           miss_c;

  // RAM port and read-check decode from state and address counter
  always_comb begin
    ram_we  = 1'b0;
    ram_adr = adr;
    ram_din = P0;
    rd_c    = 1'b0;
    exp_c   = P0;
    case (state)
      IDLE: ram_adr = '0;
      ZCHK: begin ram_adr = '0; rd_c = 1'b1; end
      M0:   ram_we = 1'b1;
      M1R:  rd_c = 1'b1;
      M1W:  begin ram_we = 1'b1; ram_din = P1; end
      M2R:  begin rd_c = 1'b1; exp_c = P1; end
      M2W:  ram_we = 1'b1;
      M3R:  rd_c = 1'b1;
      M3W:  begin ram_we = 1'b1; ram_din = P1; end
      M4R:  begin rd_c = 1'b1; exp_c = P1; end
      M4W:  ram_we = 1'b1;
      M5:   rd_c = 1'b1;
      default: ;
    endcase
  end

  // Read data is combinational, so the compare happens in the address cycle
  assign miss_c = rd_c && (ram_dout != exp_c);

  // March sequencer: state, address counter and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      adr      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_adr <= '0;
    end else if (miss_c) begin
      state    <= IDLE;
      adr      <= '0;
      busy     <= 1'b0;
      done     <= 1'b1;
      pass     <= 1'b0;
      fail_adr <= ram_adr;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ZCHK;
            adr      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_adr <= '0;
          end
        end
        ZCHK: begin
          adr   <= ADR_FIRST;
          state <= M0;
        end
        M0: begin
          if (adr == ADR_LAST) begin
            adr   <= ADR_FIRST;
            state <= M1R;
          end else begin
            adr <= adr + N'(1);
          end
        end
        M1R: state <= M1W;
        M1W: begin
          if (adr == ADR_LAST) begin
            adr   <= ADR_FIRST;
            state <= M2R;
          end else begin
            adr   <= adr + N'(1);
            state <= M1R;
          end
        end
        M2R: state <= M2W;
        M2W: begin
          if (adr == ADR_LAST) begin
            adr   <= ADR_LAST;
            state <= M3R;
          end else begin
            adr   <= adr + N'(1);
            state <= M2R;
          end
        end
        M3R: state <= M3W;
        M3W: begin
          if (adr == ADR_FIRST) begin
            adr   <= ADR_LAST;
            state <= M4R;
          end else begin
            adr   <= adr - N'(1);
            state <= M3R;
          end
        end
        M4R: state <= M4W;
        M4W: begin
          if (adr == ADR_FIRST) begin
            adr   <= ADR_LAST;
            state <= M5;
          end else begin
            adr   <= adr - N'(1);
            state <= M4R;
          end
        end
        M5: begin
          if (adr == ADR_FIRST) begin
            state    <= IDLE;
            adr      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b1;
            fail_adr <= '0;
          end else begin
            adr <= adr - N'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: faulty-RAM environment, March C- reference model,
// scoreboard queue of expected run results checked when done rises.
module tb_ram_bist;

  localparam int N = 4;
  localparam int M = 32;
  localparam int A = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, pass;
  logic [N-1:0] fail_adr;
  logic         ram_we;
  logic [N-1:0] ram_adr;
  logic [M-1:0] ram_din;
  logic [M-1:0] ram_dout;

  ram_bist #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_adr(fail_adr), .ram_we(ram_we), .ram_adr(ram_adr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Fault selection: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 adr0 reads 1,
  // 4 write to fa also writes fb
  int ftype = 0, fa = 1, fb = 2, fbit = 0;

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0;

  typedef struct { bit p; int fad; int cyc; int wr; } exp_t;
  typedef struct { bit w; int a; logic [M-1:0] d; } op_t;
  exp_t exp_q[$];

  logic [M-1:0] mem [2**N];

  function automatic logic [M-1:0] fault_read(int a, logic [M-1:0] v,
                                              int ft, int fadr, int fb_i);
    logic [M-1:0] r;
    r = v;
    if (a == 0) return (ft == 3) ? M'(1) : '0;
    if (ft == 1 && a == fadr) r[fb_i] = 1'b0;
    if (ft == 2 && a == fadr) r[fb_i] = 1'b1;
    return r;
  endfunction

  // Faulty RAM: asynchronous read, synchronous write
  always_comb ram_dout = fault_read(int'(ram_adr), mem[ram_adr], ftype, fa, fbit);

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_adr != '0) mem[ram_adr] <= ram_din;
      if (ftype == 4 && int'(ram_adr) == fa) mem[N'(fb)] <= ram_din;
    end
  end

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: expand March C- into an operation list and execute it
  function automatic void model(output bit p, output int fad,
                                output int cyc, output int wr);
    logic [M-1:0] m [A+1];
    logic [M-1:0] ones, v;
    op_t ops[$];
    ones = '1;
    for (int i = 0; i <= A; i++) m[i] = '0;
    ops.push_back('{w:1'b0, a:0, d:'0});
    for (int i = 1; i <= A; i++) ops.push_back('{w:1'b1, a:i, d:'0});
    for (int i = 1; i <= A; i++) begin
      ops.push_back('{w:1'b0, a:i, d:'0});
      ops.push_back('{w:1'b1, a:i, d:ones});
    end
    for (int i = 1; i <= A; i++) begin
      ops.push_back('{w:1'b0, a:i, d:ones});
      ops.push_back('{w:1'b1, a:i, d:'0});
    end
    for (int i = A; i >= 1; i--) begin
      ops.push_back('{w:1'b0, a:i, d:'0});
      ops.push_back('{w:1'b1, a:i, d:ones});
    end
    for (int i = A; i >= 1; i--) begin
      ops.push_back('{w:1'b0, a:i, d:ones});
      ops.push_back('{w:1'b1, a:i, d:'0});
    end
    for (int i = A; i >= 1; i--) ops.push_back('{w:1'b0, a:i, d:'0});
    p = 1'b1; fad = 0; cyc = 0; wr = 0;
    foreach (ops[k]) begin
      cyc++;
      if (ops[k].w) begin
        wr++;
        m[ops[k].a] = ops[k].d;
        if (ftype == 4 && ops[k].a == fa) m[fb] = ops[k].d;
      end else begin
        v = fault_read(ops[k].a, m[ops[k].a], ftype, fa, fbit);
        if (v != ops[k].d) begin
          p = 1'b0;
          fad = ops[k].a;
          break;
        end
      end
    end
  endfunction

  // Monitor: counts busy cycles and writes, checks result when done rises
  int  busy_cyc = 0, wr_cnt = 0, wr0 = 0;
  bit  prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cyc = 0; wr_cnt = 0; wr0 = 0; prev_done = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (ram_we) begin
        wr_cnt++;
        if (ram_adr == '0) wr0++;
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pass", int'(pass), int'(e.p));
          check("fail_adr", int'(fail_adr), e.fad);
          check("busy_cycles", busy_cyc, e.cyc);
          check("write_count", wr_cnt, e.wr);
          check("writes_to_adr0", wr0, 0);
          check("busy_after_done", int'(busy), 0);
        end
        busy_cyc = 0; wr_cnt = 0; wr0 = 0;
        n_done++;
      end
      prev_done = done;
    end
  end

  task automatic push_expect();
    exp_t e;
    model(e.p, e.fad, e.cyc, e.wr);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(int target);
    for (int i = 0; i < 400 * (target - n_done) && n_done < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("run_completes", int'(n_done >= target), 1);
    if (n_done < target) exp_q.delete();
  endtask

  task automatic run(int ft, int a1, int a2, int b, bit toggles);
    int target;
    ftype = ft; fa = a1; fb = a2; fbit = b;
    push_expect();
    target = n_done + 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (toggles) begin
      repeat (8) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (49) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    wait_done(target);
  endtask

  initial begin
    int ft, a1, a2, b, target;
    for (int i = 0; i < 2**N; i++) mem[i] = M'($urandom);
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_fail_adr", int'(fail_adr), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_adr", int'(ram_adr), 0);
    check("rst_ram_din", int'(ram_din), 0);
    @(negedge clk); #2 rst = 1'b0;

    // Directed: fault-free, stuck-at-0, adr0 nonzero, decoder coupling
    run(0, 1, 2, 0, 1'b0);
    run(1, 9, 1, 5, 1'b0);
    run(3, 1, 2, 0, 1'b0);
    run(4, 3, 7, 0, 1'b0);

    // start pulses mid-run must be ignored
    run(0, 1, 2, 0, 1'b1);

    // Reset at cycle 40 of a run aborts immediately
    ftype = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_ram_we", int'(ram_we), 0);
    check("abort_ram_adr", int'(ram_adr), 0);
    @(negedge clk); #2 rst = 1'b0;
    run(0, 1, 2, 0, 1'b0);

    // Held start retriggers after done
    ftype = 0;
    push_expect();
    push_expect();
    target = n_done + 2;
    @(negedge clk); start = 1'b1;
    wait_done(target);
    start = 1'b0;

    // Randomized faults
    for (int r = 0; r < 24; r++) begin
      ft = int'($urandom_range(0, 4));
      a1 = int'($urandom_range(1, A));
      a2 = a1;
      while (a2 == a1) a2 = int'($urandom_range(1, A));
      b  = int'($urandom_range(0, M - 1));
      run(ft, a1, a2, b, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
